// File: rtl/seg_display_write_sequencer.sv
// seg_display_write_sequencer
// Owns the write port of the 8-digit seven-segment register block. Two
// requesters hand over a 32-bit word plus a per-digit mask. Requests are
// arbitrated round-robin. The accepted word is then written digit by digit
// in ascending index order, and each digit holds write high for HOLD_CYCLES.
//
// Handshake: a request is accepted on a rising clk edge where
// req_x_valid && req_x_ready. Ready is combinational, only ever high in IDLE
// outside reset, and never high for both requesters at once. Once a request
// is accepted, its data and mask are latched, so later changes on the
// requester inputs have no effect until the block is back in IDLE.
module seg_display_write_sequencer #(
    parameter int DIGITS      = 8,
    parameter int SEL_W       = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a_valid,
    input  logic [4*DIGITS-1:0]   req_a_data,
    input  logic [DIGITS-1:0]     req_a_mask,
    output logic                  req_a_ready,
    input  logic                  req_b_valid,
    input  logic [4*DIGITS-1:0]   req_b_data,
    input  logic [DIGITS-1:0]     req_b_mask,
    output logic                  req_b_ready,
    output logic [3:0]            num,
    output logic [SEL_W-1:0]      sel,
    output logic                  write,
    output logic                  busy,
    output logic                  done,
    output logic                  grant_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t                state;
    logic [4*DIGITS-1:0]   data_q;
    logic [DIGITS-1:0]     mask_q;
    logic [3:0]            hold_cnt;
    logic                  last_grant_b;

    logic                  grant_a_c;
    logic                  grant_b_c;
    logic                  idle_ok;
    logic [4*DIGITS-1:0]   acc_data;
    logic [DIGITS-1:0]     acc_mask;
    logic [SEL_W-1:0]      acc_idx;
    logic [DIGITS-1:0]     mask_rem;
    logic [SEL_W-1:0]      next_idx;

    // Index of the lowest set bit. Returns 0 for an all-zero mask; callers
    // only use the result when the mask is non-zero.
    function automatic logic [SEL_W-1:0] lowest_idx(input logic [DIGITS-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    // Round-robin grant: a lone requester always wins; on a tie the side
    // opposite the last grant wins.
    always_comb begin
        grant_a_c = req_a_valid && (!req_b_valid || last_grant_b);
        grant_b_c = req_b_valid && !grant_a_c;
        idle_ok   = (state == IDLE) && !reset;
        acc_data  = grant_b_c ? req_b_data : req_a_data;
        acc_mask  = grant_b_c ? req_b_mask : req_a_mask;
        acc_idx   = lowest_idx(acc_mask);
    end

    assign req_a_ready = idle_ok && grant_a_c;
    assign req_b_ready = idle_ok && grant_b_c;

    // The mask that remains once the digit on sel is finished, and the digit that follows it.
    always_comb begin
        mask_rem      = mask_q;
        mask_rem[sel] = 1'b0;
        next_idx      = lowest_idx(mask_rem);
    end

    // Sequencer FSM. Every display-side output is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            data_q       <= '0;
            mask_q       <= '0;
            hold_cnt     <= '0;
            last_grant_b <= 1'b1;
            num          <= '0;
            sel          <= '0;
            write        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            grant_b      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (req_a_ready || req_b_ready) begin
                        data_q       <= acc_data;
                        mask_q       <= acc_mask;
                        grant_b      <= req_b_ready;
                        last_grant_b <= req_b_ready;
                        busy         <= 1'b1;
                        hold_cnt     <= '0;
                        if (|acc_mask) begin
                            // Present the first digit right away so write
                            // is high in the cycle after accept.
                            state <= WRITE;
                            sel   <= acc_idx;
                            num   <= acc_data[4*acc_idx +: 4];
                            write <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        mask_q   <= mask_rem;
                        if (|mask_rem) begin
                            // Move to the next digit with no gap in write.
                            sel <= next_idx;
                            num <= data_q[4*next_idx +: 4];
                        end else begin
                            write <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_write_sequencer.sv
// tb_seg_display_write_sequencer
// Directed bench. Expected (sel,num) write beats are queued when a request
// is accepted, and a negedge monitor pops and compares them as the DUT
// writes.
module tb_seg_display_write_sequencer;

    localparam int DIGITS = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD   = 2;

    logic                clk;
    logic                reset;
    logic                req_a_valid;
    logic [4*DIGITS-1:0] req_a_data;
    logic [DIGITS-1:0]   req_a_mask;
    logic                req_a_ready;
    logic                req_b_valid;
    logic [4*DIGITS-1:0] req_b_data;
    logic [DIGITS-1:0]   req_b_mask;
    logic                req_b_ready;
    logic [3:0]          num;
    logic [SEL_W-1:0]    sel;
    logic                write;
    logic                busy;
    logic                done;
    logic                grant_b;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    logic [SEL_W+3:0] exp_q[$];

    seg_display_write_sequencer #(
        .DIGITS(DIGITS), .SEL_W(SEL_W), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .reset(reset),
        .req_a_valid(req_a_valid), .req_a_data(req_a_data),
        .req_a_mask(req_a_mask), .req_a_ready(req_a_ready),
        .req_b_valid(req_b_valid), .req_b_data(req_b_data),
        .req_b_mask(req_b_mask), .req_b_ready(req_b_ready),
        .num(num), .sel(sel), .write(write),
        .busy(busy), .done(done), .grant_b(grant_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input logic [31:0] d, input logic [7:0] m);
        for (int i = 0; i < DIGITS; i++) begin
            if (m[i]) begin
                repeat (HOLD) exp_q.push_back({SEL_W'(i), d[4*i +: 4]});
            end
        end
    endtask

    // Drive a request at a negedge and wait (bounded) for ready; returns just before the accepting edge.
    task automatic start_req(input bit use_b, input logic [31:0] d, input logic [7:0] m);
        bit ok;
        @(negedge clk);
        if (use_b) begin
            req_b_valid = 1'b1; req_b_data = d; req_b_mask = m;
        end else begin
            req_a_valid = 1'b1; req_a_data = d; req_a_mask = m;
        end
        #1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (use_b ? req_b_ready : req_a_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("ready_seen", {31'd0, ok}, 1);
        if (ok) push_expected(d, m);
    endtask

    // Count negedges after the accepting edge until done, then check the done cycle.
    task automatic finish_req(input bit exp_b, input logic [7:0] m, input bit drop);
        int k;
        int lat;
        k   = 0;
        lat = 1 + HOLD * $countones(m);
        while (k < 300) begin
            @(negedge clk);
            k++;
            if (k == 1 && drop) begin
                req_a_valid = 1'b0;
                req_b_valid = 1'b0;
            end
            if (done) break;
        end
        chk("done_latency", k, lat);
        chk("done_grant_b", {31'd0, grant_b}, {31'd0, exp_b});
        chk("done_write_low", {31'd0, write}, 0);
        chk("done_busy_high", {31'd0, busy}, 1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("busy_after_done", {31'd0, busy}, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [SEL_W+3:0] e;
        if (!reset) begin
            if (write) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {31'd0, write}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_sel_num", {25'd0, sel, num}, {25'd0, e});
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_queue_empty", exp_q.size(), 0);
            end
            chk("ready_exclusive", {31'd0, req_a_ready && req_b_ready}, 0);
            if (busy) chk("ready_low_busy", {31'd0, req_a_ready || req_b_ready}, 0);
        end
    end

    // Directed steps
    initial begin
        int dc;
        bit found;
        reset       = 1'b1;
        req_a_valid = 1'b1;
        req_a_data  = 32'h1111_1111;
        req_a_mask  = 8'hFF;
        req_b_valid = 1'b1;
        req_b_data  = 32'h2222_2222;
        req_b_mask  = 8'hFF;

        // Reset with both requesters valid
        repeat (3) @(negedge clk);
        chk("rst_write", {31'd0, write}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_sel", {29'd0, sel}, 0);
        chk("rst_num", {28'd0, num}, 0);
        chk("rst_grant_b", {31'd0, grant_b}, 0);
        chk("rst_ready_a", {31'd0, req_a_ready}, 0);
        chk("rst_ready_b", {31'd0, req_b_ready}, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready_a", {31'd0, req_a_ready}, 1);
        chk("post_rst_ready_b", {31'd0, req_b_ready}, 0);
        // Valid dropped before any edge: no accept
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_accept_busy", {31'd0, busy}, 0);
        chk("no_accept_write", {31'd0, write}, 0);

        // Full word from A
        start_req(1'b0, 32'h8765_4321, 8'hFF);
        finish_req(1'b0, 8'hFF, 1'b1);

        // Sparse mask from A
        start_req(1'b0, 32'hC000_0A00, 8'b1000_0100);
        finish_req(1'b0, 8'b1000_0100, 1'b1);

        // Zero mask from B
        start_req(1'b1, 32'h1234_5678, 8'h00);
        finish_req(1'b1, 8'h00, 1'b1);
        req_b_valid = 1'b1;
        #1;
        chk("ready_after_done", {31'd0, req_b_ready}, 1);
        req_b_valid = 1'b0;

        // Both valid continuously: A,B,A,B
        @(negedge clk);
        req_a_data  = 32'h0000_0005; req_a_mask = 8'h01; req_a_valid = 1'b1;
        req_b_data  = 32'h0000_0009; req_b_mask = 8'h01; req_b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit exp_b;
            exp_b = i[0];
            #1;
            for (int w = 0; w < 20 && !(req_a_ready || req_b_ready); w++) begin
                @(negedge clk);
                #1;
            end
            chk("arb_ready_a", {31'd0, req_a_ready}, {31'd0, !exp_b});
            chk("arb_ready_b", {31'd0, req_b_ready}, {31'd0, exp_b});
            push_expected(exp_b ? req_b_data : req_a_data, 8'h01);
            finish_req(exp_b, 8'h01, i == 3);
        end

        // Reset in the middle of a write
        start_req(1'b0, 32'h8765_4321, 8'hFF);
        @(negedge clk);
        req_a_valid = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 40; w++) begin
            if (write && sel == 3'd3) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reached_sel3", {31'd0, found}, 1);
        reset = 1'b1;
        #1;
        chk("midrst_write", {31'd0, write}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_sel", {29'd0, sel}, 0);
        exp_q.delete();
        dc = done_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_done_after_rst", done_cnt, dc);
        start_req(1'b0, 32'hFEDC_BA98, 8'hFF);
        finish_req(1'b0, 8'hFF, 1'b1);

        repeat (2) @(negedge clk);
        chk("queue_empty_end", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
